// File: rtl/hmc7044_cfg_seq.sv
// HMC7044 register-table sequencer: walks a table of address/data entries and hands each one
// to the SPI shift engine as a 24-bit write frame over a req/ack handshake.
module hmc7044_cfg_seq #(
    parameter int unsigned NUM_REGS       = 8,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned AW             = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] tbl_addr,
    input  logic [20:0]   tbl_data,
    output logic          spi_req,
    output logic [23:0]   spi_frame,
    input  logic          spi_ack
);

    // One counter serves both the inter-frame gap and the ack timeout.
    localparam int unsigned CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StSend,
        StGap,
        StDone,
        StErr
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          req_q, req_d;
    logic [23:0]   frame_q, frame_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        req_d   = req_q;
        frame_d = frame_q;

        unique case (state_q)
            StIdle: begin
                // busy is still high for the first idle cycle after a done pulse
                busy_d = 1'b0;
                if (start) begin
                    state_d = StFetch;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StFetch: begin
                state_d = StLatch;
            end
            StLatch: begin
                frame_d = {3'b000, tbl_data};
                cnt_d   = '0;
                req_d   = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (spi_ack) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = StFetch;
                    end
                end else if (TIMEOUT_CYCLES > 0) begin
                    if (cnt_q == TO_LAST) begin
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = StErr;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = StFetch;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            frame_q <= frame_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign tbl_addr  = idx_q;
    assign spi_req   = req_q;
    assign spi_frame = frame_q;

endmodule

// File: tb/tb_hmc7044_cfg_seq.sv
// Bench for hmc7044_cfg_seq: directed runs on four parameterisations, frames checked
// against a scoreboard of expected SPI words.
module tb_hmc7044_cfg_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [12:0] reg_addr [4] = '{13'h0001, 13'h0003, 13'h0054, 13'h0001};
    logic [7:0]  reg_dat  [4] = '{8'h61, 8'h37, 8'h10, 8'h60};
    logic [23:0] exp_frames [4] = '{24'h000161, 24'h000337, 24'h005410, 24'h000160};

    function automatic logic [20:0] rom_rd(input int i);
        return {reg_addr[i], reg_dat[i]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Instance A: NUM_REGS=4, G=2, T=64
    logic        start_a, busy_a, done_a, err_a, spi_req_a, spi_ack_a, eng_ack, stray_ack;
    logic [1:0]  tbl_addr_a;
    logic [20:0] tbl_data_a;
    logic [23:0] spi_frame_a;
    assign spi_ack_a = eng_ack | stray_ack;

    hmc7044_cfg_seq #(.NUM_REGS(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(64)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .err(err_a),
        .tbl_addr(tbl_addr_a), .tbl_data(tbl_data_a), .spi_req(spi_req_a),
        .spi_frame(spi_frame_a), .spi_ack(spi_ack_a)
    );

    // Instances B (G=0) and C (G=5) share start and ack so their gaps can be compared directly
    logic        start_bc, ack_bc;
    logic        busy_b, done_b, err_b, spi_req_b, busy_c, done_c, err_c, spi_req_c;
    logic [0:0]  tbl_addr_b, tbl_addr_c;
    logic [20:0] tbl_data_b, tbl_data_c;
    logic [23:0] spi_frame_b, spi_frame_c;

    hmc7044_cfg_seq #(.NUM_REGS(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(64)) u_b (
        .clk(clk), .rst(rst), .start(start_bc), .busy(busy_b), .done(done_b), .err(err_b),
        .tbl_addr(tbl_addr_b), .tbl_data(tbl_data_b), .spi_req(spi_req_b),
        .spi_frame(spi_frame_b), .spi_ack(ack_bc)
    );

    hmc7044_cfg_seq #(.NUM_REGS(2), .GAP_CYCLES(5), .TIMEOUT_CYCLES(64)) u_c (
        .clk(clk), .rst(rst), .start(start_bc), .busy(busy_c), .done(done_c), .err(err_c),
        .tbl_addr(tbl_addr_c), .tbl_data(tbl_data_c), .spi_req(spi_req_c),
        .spi_frame(spi_frame_c), .spi_ack(ack_bc)
    );

    // Instance D: single entry, short timeout
    logic        start_d, ack_d, busy_d, done_d, err_d, spi_req_d;
    logic [0:0]  tbl_addr_d;
    logic [20:0] tbl_data_d;
    logic [23:0] spi_frame_d;

    hmc7044_cfg_seq #(.NUM_REGS(1), .GAP_CYCLES(0), .TIMEOUT_CYCLES(8)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .busy(busy_d), .done(done_d), .err(err_d),
        .tbl_addr(tbl_addr_d), .tbl_data(tbl_data_d), .spi_req(spi_req_d),
        .spi_frame(spi_frame_d), .spi_ack(ack_d)
    );

    // External table ROMs with one cycle of read latency
    always @(posedge clk) begin
        tbl_data_a <= rom_rd(int'(tbl_addr_a));
        tbl_data_b <= rom_rd(int'(tbl_addr_b));
        tbl_data_c <= rom_rd(int'(tbl_addr_c));
        tbl_data_d <= rom_rd(int'(tbl_addr_d));
    end

    // SPI engine model for A: pops the scoreboard on each new frame, acks after ack_lat cycles
    logic [23:0] exp_q [$];
    logic [23:0] exp_w;
    int ack_lat    = 30;
    int drop_frame = -1;
    int frames_a   = 0;
    int done_cnt_a = 0;
    int req_len    = 0;
    int last_len   = 0;

    initial begin
        eng_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            eng_ack = 1'b0;
            if (done_a) done_cnt_a++;
            if (spi_req_a) begin
                if (req_len == 0) begin
                    frames_a++;
                    check("a_sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_w = exp_q.pop_front();
                        check("a_frame", 32'(spi_frame_a), 32'(exp_w));
                    end
                    check("a_busy_in_send", 32'(busy_a), 32'd1);
                end
                req_len++;
                if (frames_a != drop_frame && req_len == ack_lat) eng_ack = 1'b1;
            end else begin
                if (req_len != 0) last_len = req_len;
                req_len = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_run();
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_frames[i]);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    int n, nb, nc, base, dbase;

    initial begin
        rst = 1'b1; start_a = 1'b0; start_bc = 1'b0; start_d = 1'b0;
        stray_ack = 1'b0; ack_bc = 1'b0; ack_d = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_req", 32'(spi_req_a), 32'd0);
        check("rst_frame", 32'(spi_frame_a), 32'd0);
        check("rst_addr", 32'(tbl_addr_a), 32'd0);

        // Stray ack while idle
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_ack_no_req", 32'(spi_req_a), 32'd0);
        check("idle_ack_no_frame", 32'(frames_a), 32'd0);

        // Nominal run with ignored start and stray ack in GAP
        push_run();
        pulse_start_a();
        check("start_busy", 32'(busy_a), 32'd1);
        check("start_addr", 32'(tbl_addr_a), 32'd0);
        pulse_start_a();
        n = 0;
        while ((frames_a < 1 || spi_req_a) && n < 500) begin @(negedge clk); n++; end
        check("first_ack_seen", 32'(n < 500), 32'd1);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        pulse_start_a();
        n = 0;
        while (!done_a && n < 2000) begin @(negedge clk); n++; end
        check("nom_done_seen", 32'(done_a), 32'd1);
        check("nom_busy_at_done", 32'(busy_a), 32'd1);
        check("nom_err", 32'(err_a), 32'd0);
        check("nom_frames", 32'(frames_a), 32'd4);
        check("nom_sb_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("nom_busy_low", 32'(busy_a), 32'd0);
        check("nom_done_low", 32'(done_a), 32'd0);
        repeat (10) @(negedge clk);
        check("nom_one_done", 32'(done_cnt_a), 32'd1);
        check("nom_no_extra_frame", 32'(frames_a), 32'd4);

        // Timeout on the second frame
        base = frames_a;
        dbase = done_cnt_a;
        exp_q.push_back(exp_frames[0]);
        exp_q.push_back(exp_frames[1]);
        drop_frame = base + 2;
        pulse_start_a();
        n = 0;
        while (!err_a && n < 3000) begin @(negedge clk); n++; end
        check("to_err", 32'(err_a), 32'd1);
        check("to_busy", 32'(busy_a), 32'd0);
        check("to_req", 32'(spi_req_a), 32'd0);
        check("to_req_len", 32'(last_len), 32'd64);
        check("to_frames", 32'(frames_a - base), 32'd2);
        repeat (5) @(negedge clk);
        check("to_err_sticky", 32'(err_a), 32'd1);
        check("to_no_done", 32'(done_cnt_a - dbase), 32'd0);

        // Rerun clears err and completes
        drop_frame = -1;
        base = frames_a;
        push_run();
        pulse_start_a();
        check("rerun_err_clr", 32'(err_a), 32'd0);
        n = 0;
        while (!done_a && n < 2000) begin @(negedge clk); n++; end
        check("rerun_done", 32'(done_a), 32'd1);
        check("rerun_frames", 32'(frames_a - base), 32'd4);
        check("rerun_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-SEND
        repeat (3) @(negedge clk);
        push_run();
        pulse_start_a();
        n = 0;
        while (!spi_req_a && n < 20) begin @(negedge clk); n++; end
        check("mid_req_seen", 32'(spi_req_a), 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req", 32'(spi_req_a), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("post_rst_req", 32'(spi_req_a), 32'd0);
        check("post_rst_busy", 32'(busy_a), 32'd0);
        check("post_rst_done", 32'(done_a), 32'd0);
        check("post_rst_err", 32'(err_a), 32'd0);
        check("post_rst_addr", 32'(tbl_addr_a), 32'd0);
        base = frames_a;
        push_run();
        pulse_start_a();
        check("post_rst_start_addr", 32'(tbl_addr_a), 32'd0);
        n = 0;
        while (!done_a && n < 2000) begin @(negedge clk); n++; end
        check("post_rst_done_seen", 32'(done_a), 32'd1);
        check("post_rst_frames", 32'(frames_a - base), 32'd4);

        // Gap 0 vs gap 5: ack-to-next-req distance
        start_bc = 1'b1;
        @(negedge clk);
        start_bc = 1'b0;
        n = 0;
        while (!spi_req_b && n < 20) begin @(negedge clk); n++; end
        check("b_frame0", 32'(spi_frame_b), 32'h000161);
        check("c_frame0", 32'(spi_frame_c), 32'h000161);
        repeat (2) @(negedge clk);
        ack_bc = 1'b1;
        @(negedge clk);
        ack_bc = 1'b0;
        nb = 0;
        nc = 0;
        for (int k = 1; k <= 20; k++) begin
            if (spi_req_b && nb == 0) nb = k;
            if (spi_req_c && nc == 0) nc = k;
            @(negedge clk);
        end
        check("gap0_latency", 32'(nb), 32'd3);
        check("gap5_latency", 32'(nc), 32'd8);
        check("b_frame1", 32'(spi_frame_b), 32'h000337);
        check("c_frame1", 32'(spi_frame_c), 32'h000337);
        ack_bc = 1'b1;
        @(negedge clk);
        ack_bc = 1'b0;
        repeat (12) @(negedge clk);
        check("b_idle", 32'(busy_b), 32'd0);
        check("c_idle", 32'(busy_c), 32'd0);
        check("bc_no_err", 32'({err_b, err_c}), 32'd0);

        // Single entry, ack lands on the cycle the timeout expires
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        n = 0;
        while (!spi_req_d && n < 20) begin @(negedge clk); n++; end
        check("d_req_seen", 32'(spi_req_d), 32'd1);
        check("d_frame", 32'(spi_frame_d), 32'h000161);
        repeat (7) @(negedge clk);
        check("d_req_still_high", 32'(spi_req_d), 32'd1);
        ack_d = 1'b1;
        @(negedge clk);
        ack_d = 1'b0;
        check("d_req_dropped", 32'(spi_req_d), 32'd0);
        check("d_err_after_ack", 32'(err_d), 32'd0);
        @(negedge clk);
        check("d_done", 32'(done_d), 32'd1);
        check("d_busy_at_done", 32'(busy_d), 32'd1);
        @(negedge clk);
        check("d_done_low", 32'(done_d), 32'd0);
        check("d_busy_low", 32'(busy_d), 32'd0);
        check("d_err_final", 32'(err_d), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
